// File: rtl/gcd_pkg.sv
// rtl/gcd_pkg.sv - shared types and constants for the GCD controller and datapath
//
// Purpose: one place for the controller state enumeration, operand width,
// iteration counter width and the default subtraction-step limit.
package gcd_pkg;

  localparam int WIDTH    = 16;     // default operand width
  localparam int ITER_W   = 17;     // iteration counter width
  localparam int MAX_ITER = 65535;  // default subtraction-step limit

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_SUB_A,
    S_SUB_B,
    S_DONE
  } gcd_state_t;

endpackage

// File: rtl/gcd_datapath.sv
// rtl/gcd_datapath.sv - A/B operand registers, subtractors, comparators and result mux
//
// Purpose: subtractive-GCD datapath steered by gcd_ctrl.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   a_in, b_in        external operands
//   ld_a, ld_b        register load enables
//   sel_a, sel_b      0 = load external operand, 1 = load difference
//   out_sel           0 = result from A, 1 = result from B
//   a_zero, b_zero    register equals zero
//   a_gt_b, a_eq_b    magnitude compare of A against B
//   result            selected register value
module gcd_datapath #(
  parameter int WIDTH = gcd_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             ld_a,
  input  logic             ld_b,
  input  logic             sel_a,
  input  logic             sel_b,
  input  logic             out_sel,
  output logic             a_zero,
  output logic             b_zero,
  output logic             a_gt_b,
  output logic             a_eq_b,
  output logic [WIDTH-1:0] result
);
  import gcd_pkg::*;

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_reg <= '0;
      b_reg <= '0;
    end else begin
      if (ld_a) a_reg <= sel_a ? (a_reg - b_reg) : a_in;
      if (ld_b) b_reg <= sel_b ? (b_reg - a_reg) : b_in;
    end
  end

  assign a_zero = (a_reg == '0);
  assign b_zero = (b_reg == '0);
  assign a_gt_b = (a_reg > b_reg);
  assign a_eq_b = (a_reg == b_reg);
  assign result = out_sel ? b_reg : a_reg;

endmodule

// File: rtl/gcd_ctrl.sv
// rtl/gcd_ctrl.sv - subtractive GCD control FSM with bounded iteration counter
//
// Purpose: sequences LOAD / CHECK / SUB_A / SUB_B / DONE over an external
// GCD datapath and flags a timeout after MAX_ITER subtraction steps.
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   start                       request a computation (accepted in IDLE only)
//   a_zero, b_zero              datapath register-is-zero flags
//   a_gt_b, a_eq_b              datapath compare flags
//   ld_a, ld_b, sel_a, sel_b    datapath register controls (Moore)
//   out_sel                     result mux select, held from DONE until LOAD
//   busy, done                  not-idle flag, one-cycle completion pulse (Moore)
//   err                         timeout flag, held from DONE until LOAD
//   iter_cnt                    subtraction steps of current/last computation
module gcd_ctrl #(
  parameter int WIDTH    = gcd_pkg::WIDTH,
  parameter int MAX_ITER = gcd_pkg::MAX_ITER
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      a_zero,
  input  logic                      b_zero,
  input  logic                      a_gt_b,
  input  logic                      a_eq_b,
  output logic                      ld_a,
  output logic                      ld_b,
  output logic                      sel_a,
  output logic                      sel_b,
  output logic                      out_sel,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic [gcd_pkg::ITER_W-1:0] iter_cnt
);
  import gcd_pkg::*;

  // The counter must be able to hold MAX_ITER itself so it never wraps.
  if (WIDTH < 1 || MAX_ITER < 0 || MAX_ITER >= (1 << ITER_W)) begin : g_bad_param
    $error("gcd_ctrl: WIDTH or MAX_ITER out of range");
  end

  localparam logic [ITER_W-1:0] ITER_LIMIT = ITER_W'(MAX_ITER);

  gcd_state_t        state, state_nxt;
  logic [ITER_W-1:0] iter_nxt;
  logic              err_nxt;
  logic              out_sel_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      iter_cnt <= '0;
      err      <= 1'b0;
      out_sel  <= 1'b0;
    end else begin
      state    <= state_nxt;
      iter_cnt <= iter_nxt;
      err      <= err_nxt;
      out_sel  <= out_sel_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    iter_nxt    = iter_cnt;
    err_nxt     = err;
    out_sel_nxt = out_sel;
    ld_a        = 1'b0;
    ld_b        = 1'b0;
    sel_a       = 1'b0;
    sel_b       = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;

    unique case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        ld_a        = 1'b1;
        ld_b        = 1'b1;
        iter_nxt    = '0;
        err_nxt     = 1'b0;
        out_sel_nxt = 1'b0;
        state_nxt   = S_CHECK;
      end
      S_CHECK: begin
        // Termination tests come before the step limit so a computation that
        // converges on its last permitted step still finishes cleanly.
        if (a_zero && b_zero) begin
          out_sel_nxt = 1'b0;
          state_nxt   = S_DONE;
        end else if (a_zero) begin
          out_sel_nxt = 1'b1;
          state_nxt   = S_DONE;
        end else if (b_zero || a_eq_b) begin
          out_sel_nxt = 1'b0;
          state_nxt   = S_DONE;
        end else if (iter_cnt == ITER_LIMIT) begin
          err_nxt   = 1'b1;
          state_nxt = S_DONE;
        end else if (a_gt_b) begin
          state_nxt = S_SUB_A;
        end else begin
          state_nxt = S_SUB_B;
        end
      end
      S_SUB_A: begin
        ld_a      = 1'b1;
        sel_a     = 1'b1;
        iter_nxt  = iter_cnt + 1'b1;
        state_nxt = S_CHECK;
      end
      S_SUB_B: begin
        ld_b      = 1'b1;
        sel_b     = 1'b1;
        iter_nxt  = iter_cnt + 1'b1;
        state_nxt = S_CHECK;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_gcd_ctrl.sv
// tb/tb_gcd_ctrl.sv - self-checking bench for gcd_ctrl with the GCD datapath beside it
module tb_gcd_ctrl;
  import gcd_pkg::*;

  localparam int TB_MAX = 3;
  localparam int W      = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [W-1:0]  a_ext, b_ext;
  logic          a_zero, b_zero, a_gt_b, a_eq_b;
  logic          ld_a, ld_b, sel_a, sel_b, out_sel, busy, done, err;
  logic [16:0]   iter_cnt;
  logic [W-1:0]  result;

  always #5 clk = ~clk;

  gcd_ctrl #(.WIDTH(W), .MAX_ITER(TB_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a_zero(a_zero), .b_zero(b_zero), .a_gt_b(a_gt_b), .a_eq_b(a_eq_b),
    .ld_a(ld_a), .ld_b(ld_b), .sel_a(sel_a), .sel_b(sel_b),
    .out_sel(out_sel), .busy(busy), .done(done), .err(err), .iter_cnt(iter_cnt)
  );

  gcd_datapath #(.WIDTH(W)) dp (
    .clk(clk), .rst_n(rst_n), .a_in(a_ext), .b_in(b_ext),
    .ld_a(ld_a), .ld_b(ld_b), .sel_a(sel_a), .sel_b(sel_b), .out_sel(out_sel),
    .a_zero(a_zero), .b_zero(b_zero), .a_gt_b(a_gt_b), .a_eq_b(a_eq_b),
    .result(result)
  );

  typedef struct {
    logic        busy, done, ld_a, ld_b, sel_a, sel_b, out_sel, err;
    logic [16:0] iter;
    logic        chk_res;
    logic [W-1:0] res;
  } exp_t;

  exp_t        q[$];
  logic        h_os, h_err;
  logic [16:0] h_iter;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic chk_en = 1'b0;

  int done_cnt = 0;
  int done_cyc = 0;
  int done_res = 0;
  int done_os  = 0;
  int done_err = 0;
  int done_it  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, got, exp);
    end
  endtask

  function automatic exp_t ent(input logic b, input logic d, input logic la, input logic lb,
                               input logic sa, input logic sb, input logic os,
                               input logic er, input logic [16:0] it);
    exp_t e;
    e.busy = b; e.done = d; e.ld_a = la; e.ld_b = lb; e.sel_a = sa; e.sel_b = sb;
    e.out_sel = os; e.err = er; e.iter = it; e.chk_res = 1'b0; e.res = '0;
    return e;
  endfunction

  // Cycle-by-cycle expectation of one request: an IDLE cycle in which start is
  // sampled, then the load, then the subtractive Euclid loop with its
  // termination rules, then the completion cycle.
  task automatic model_run(input int a, input int b);
    int x, y, n;
    logic os, er;
    exp_t e;
    q.push_back(ent(0, 0, 0, 0, 0, 0, h_os, h_err, h_iter));
    q.push_back(ent(1, 0, 1, 1, 0, 0, h_os, h_err, h_iter));
    x = a; y = b; n = 0; os = 0; er = 0;
    while (1) begin
      q.push_back(ent(1, 0, 0, 0, 0, 0, 0, 0, 17'(n)));
      if (x == 0 && y == 0) begin os = 0; break; end
      if (x == 0)           begin os = 1; break; end
      if (y == 0 || x == y) begin os = 0; break; end
      if (n == TB_MAX)      begin er = 1; break; end
      if (x > y) begin
        q.push_back(ent(1, 0, 1, 0, 1, 0, 0, 0, 17'(n)));
        x = x - y;
      end else begin
        q.push_back(ent(1, 0, 0, 1, 0, 1, 0, 0, 17'(n)));
        y = y - x;
      end
      n++;
    end
    e = ent(1, 1, 0, 0, 0, 0, os, er, 17'(n));
    e.chk_res = 1'b1;
    e.res = os ? W'(y) : W'(x);
    q.push_back(e);
    h_os = os; h_err = er; h_iter = 17'(n);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      exp_t e;
      if (q.size() > 0) e = q.pop_front();
      else              e = ent(0, 0, 0, 0, 0, 0, h_os, h_err, h_iter);
      chk("busy",     busy,     e.busy);
      chk("done",     done,     e.done);
      chk("ld_a",     ld_a,     e.ld_a);
      chk("ld_b",     ld_b,     e.ld_b);
      chk("sel_a",    sel_a,    e.sel_a);
      chk("sel_b",    sel_b,    e.sel_b);
      chk("out_sel",  out_sel,  e.out_sel);
      chk("err",      err,      e.err);
      chk("iter_cnt", iter_cnt, e.iter);
      if (e.chk_res) chk("result", result, e.res);
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
        done_res = int'(result);
        done_os  = int'(out_sel);
        done_err = int'(err);
        done_it  = int'(iter_cnt);
      end
    end
  end

  task automatic drain();
    int t = 0;
    while (q.size() > 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    chk("drain_timeout", q.size(), 0);
    repeat (3) @(posedge clk);
  endtask

  // Raise start for hold_cycles sampling edges; returns the launch cycle.
  task automatic launch(input int a, input int b, input int hold_cycles, output int k0);
    @(posedge clk);
    #1;
    a_ext = W'(a);
    b_ext = W'(b);
    start = 1'b1;
    k0 = cyc;
    model_run(a, b);
    repeat (hold_cycles) @(posedge clk);
    #1 start = 1'b0;
  endtask

  initial begin
    int k0, base, dc0;
    h_os = 0; h_err = 0; h_iter = '0;
    rst_n = 1'b0; start = 1'b0; a_ext = '0; b_ext = '0;
    @(posedge clk);
    #1 chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // 12, 8: LOAD CHECK SUB_A CHECK SUB_B CHECK DONE
    launch(12, 8, 1, k0);
    drain();
    chk("lat_12_8", done_cyc - k0, 7);
    chk("res_12_8", done_res, 4);
    chk("os_12_8",  done_os, 0);
    chk("it_12_8",  done_it, 2);
    chk("err_12_8", done_err, 0);

    launch(0, 9, 1, k0);
    drain();
    chk("lat_0_9", done_cyc - k0, 3);
    chk("res_0_9", done_res, 9);
    chk("os_0_9",  done_os, 1);
    chk("it_0_9",  done_it, 0);
    chk("os_held", out_sel, 1);

    launch(0, 0, 1, k0);
    drain();
    chk("res_0_0", done_res, 0);
    chk("os_0_0",  done_os, 0);

    // step limit reached with operands still unequal
    launch(100, 1, 1, k0);
    drain();
    chk("lat_100_1", done_cyc - k0, 9);
    chk("err_100_1", done_err, 1);
    chk("it_100_1",  done_it, 3);
    chk("err_held",  err, 1);

    // converges exactly on the last permitted step: no timeout
    launch(4, 1, 1, k0);
    drain();
    chk("lat_4_1", done_cyc - k0, 9);
    chk("err_4_1", done_err, 0);
    chk("res_4_1", done_res, 1);

    // start held high: one done per accepted request, relaunch from IDLE
    dc0 = done_cnt;
    @(posedge clk);
    #1;
    a_ext = 16'd12; b_ext = 16'd8; start = 1'b1;
    k0 = cyc;
    model_run(12, 8);
    model_run(12, 8);
    repeat (9) @(posedge clk);
    #1 start = 1'b0;
    drain();
    chk("held_done_cnt", done_cnt - dc0, 2);
    chk("held_lat2", done_cyc - k0, 15);

    // reset during SUB_A aborts without a done pulse
    dc0 = done_cnt;
    @(posedge clk);
    #1;
    a_ext = 16'd65535; b_ext = 16'd1; start = 1'b1;
    base = q.size();
    model_run(65535, 1);
    while (q.size() > base + 4) void'(q.pop_back());
    q.push_back(ent(0, 0, 0, 0, 0, 0, 0, 0, 17'd0));
    h_os = 0; h_err = 0; h_iter = '0;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    drain();
    chk("rst_no_done", done_cnt - dc0, 0);
    chk("rst_iter",    iter_cnt, 0);

    launch(21, 14, 1, k0);
    drain();
    chk("res_21_14", done_res, 7);
    chk("it_21_14",  done_it, 2);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
